regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write-back data.
REQ-002 Parameter REG_COUNT, default 32, number of architectural registers; AW = $clog2(REG_COUNT).
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive stalled ex cycles before ex gains priority; range 1..15.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ex_valid / ex_ready  input / output  1 / 1  execute-unit write-back handshake.
REQ-007 ex_rd / ex_data  input  AW / DATA_WIDTH  execute destination register and result.
REQ-008 ls_valid / ls_ready  input / output  1 / 1  load-store-unit write-back handshake.
REQ-009 ls_rd / ls_data  input  AW / DATA_WIDTH  load destination register and data.
REQ-010 reg_write / rd / rd_data  output  1 / AW / DATA_WIDTH  register-file write port, all registered.
REQ-011 issue_valid / issue_rd  input  1 / AW  issue stage marks a destination register pending.
REQ-012 rs1 / rs2  input  AW  issue-stage source register queries.
REQ-013 rs1_busy / rs2_busy  output  1  combinational: queried register has a write outstanding.

Function
REQ-014 Block SHALL accept at most one write-back per cycle; a transfer occurs when valid && ready on the same cycle.
REQ-015 ex_ready and ls_ready SHALL be combinational from valid inputs and priority state; never both 1 in one cycle.
REQ-016 Priority state SHALL be two-state: PRIO_LS (default) and PRIO_EX.
REQ-017 In PRIO_LS: ls_ready = ls_valid; ex_ready = ex_valid && !ls_valid.
REQ-018 In PRIO_EX: ex_ready = ex_valid; ls_ready = ls_valid && !ex_valid.
REQ-019 Starve counter (4 bits) SHALL increment on each cycle with ex_valid && !ex_ready, saturating at STARVE_LIMIT; cleared on ex transfer or when ex_valid is 0.
REQ-020 Transition PRIO_LS -> PRIO_EX SHALL occur at the edge where counter reaches STARVE_LIMIT; PRIO_EX -> PRIO_LS at the edge of the ex transfer.
REQ-021 Accepted request SHALL appear on rd/rd_data with reg_write=1 exactly one cycle after the transfer cycle (latency 1).
REQ-022 Accepted request with destination 0 SHALL be consumed (ready asserted) but reg_write SHALL be 0 the following cycle.
REQ-023 When no transfer occurs, reg_write SHALL be 0 next cycle; rd/rd_data SHALL hold their previous values.
REQ-024 Scoreboard SHALL hold one pending bit per register; bit 0 is constant 0.
REQ-025 Pending bit SHALL set at the edge of a cycle with issue_valid=1 and issue_rd!=0.
REQ-026 Pending bit SHALL clear at the edge ending a cycle with reg_write=1 for that rd.
REQ-027 Simultaneous set and clear of the same register: set SHALL win (bit remains 1).
REQ-028 rsN_busy SHALL equal pending[rsN], including during the reg_write cycle of that register; rsN=0 SHALL give 0.
REQ-029 Block SHALL not check that a write-back targets a pending register; non-pending writes commit normally.
REQ-030 Valid inputs dropped without transfer SHALL be permitted; no state SHALL change except the counter clear.

Reset
REQ-031 While rst_n=0: reg_write=0, rd=0, rd_data=0, all pending bits 0, counter 0, state PRIO_LS, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard any accepted-but-uncommitted write (no reg_write after release).
REQ-033 First transfer SHALL be possible in the first rising edge after rst_n deasserts.

Verification
REQ-034 Single ex write: ex_valid=1, ex_rd=5, ex_data=0xDEADBEEF for 1 cycle -> ex_ready=1 same cycle; next cycle reg_write=1, rd=5, rd_data=0xDEADBEEF; following cycle reg_write=0.
REQ-035 Contention: ex_valid and ls_valid held 1 continuously, STARVE_LIMIT=4 -> ls accepted cycles 0-3, ex accepted cycle 4, ls cycle 5; ready never both 1.
REQ-036 x0 write: ls_valid=1, ls_rd=0, ls_data=0x1234 -> ls_ready=1; next cycle reg_write=0.
REQ-037 Scoreboard: issue_valid=1, issue_rd=7; rs1=7 -> rs1_busy=1 next cycle; ex write rd=7 -> busy stays 1 through reg_write cycle, 0 after; same-cycle reissue of 7 during reg_write -> busy stays 1.
REQ-038 Reset mid-flight: ex transfer rd=9 then rst_n=0 before next edge -> reg_write stays 0, rd=0, rs1_busy for 9 = 0, state PRIO_LS after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - Two-source write-back arbiter with anti-starvation priority
// and a pending-register scoreboard for issue-stage hazard queries.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [AW-1:0]         ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [AW-1:0]         ls_rd,
  input  logic [DATA_WIDTH-1:0] ls_data,
  output logic                  reg_write,
  output logic [AW-1:0]         rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  typedef enum logic {PRIO_LS, PRIO_EX} prio_t;

  localparam int         NREG  = 1 << AW;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  prio_t           state, state_next;
  logic [3:0]      starve_cnt, starve_next;
  logic            ex_xfer, ls_xfer;
  logic [NREG-1:0] pending, pending_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIO_LS;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    ex_ready    = 1'b0;
    ls_ready    = 1'b0;
    state_next  = state;
    starve_next = starve_cnt;
    if (state == PRIO_LS) begin
      ls_ready = ls_valid;
      ex_ready = ex_valid && !ls_valid;
    end else begin
      ex_ready = ex_valid;
      ls_ready = ls_valid && !ex_valid;
    end
    if (!ex_valid || ex_ready) begin
      starve_next = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_next = starve_cnt + 4'd1;
    end
    // EX keeps priority until it actually transfers, even if it drops valid meanwhile.
    if (state == PRIO_LS && starve_next == LIMIT) begin
      state_next = PRIO_EX;
    end else if (state == PRIO_EX && ex_ready) begin
      state_next = PRIO_LS;
    end
  end

  assign ex_xfer = ex_valid && ex_ready;
  assign ls_xfer = ls_valid && ls_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else begin
      reg_write <= 1'b0;
      if (ex_xfer) begin
        reg_write <= (ex_rd != '0);
        rd        <= ex_rd;
        rd_data   <= ex_data;
      end else if (ls_xfer) begin
        reg_write <= (ls_rd != '0);
        rd        <= ls_rd;
        rd_data   <= ls_data;
      end
    end
  end

  // A new issue to the register being committed this cycle must keep it pending.
  always_comb begin
    pending_next = pending;
    if (reg_write) begin
      pending_next[rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - Scoreboard bench: directed write-back, priority,
// scoreboard and reset vectors; a monitor checks every commit against a queue.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ls_valid, ls_ready;
  logic [4:0]  ls_rd;
  logic [31:0] ls_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rd(ls_rd), .ls_data(ls_data),
    .reg_write(reg_write), .rd(rd), .rd_data(rd_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Commits must arrive in order, exactly one cycle after their transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (reg_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_reg_write", 32'(reg_write), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_rd", 32'(rd), 32'(mon_e.rd));
          check("commit_data", rd_data, mon_e.data);
          check("commit_latency", 32'(cyc - mon_e.cyc), 32'd1);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc + 1 <= cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_reg_write", 32'(reg_write), 32'd1);
      end
    end
  end

  task automatic step(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic exp_er, input logic exp_lr);
    exp_t e;
    ex_valid = ev; ex_rd = er; ex_data = ed;
    ls_valid = lv; ls_rd = lr; ls_data = ld;
    @(negedge clk);
    check("ex_ready", 32'(ex_ready), 32'(exp_er));
    check("ls_ready", 32'(ls_ready), 32'(exp_lr));
    if (exp_er && ev && er != 5'd0) begin
      e.rd = er; e.data = ed; e.cyc = cyc; exp_q.push_back(e);
    end
    if (exp_lr && lv && lr != 5'd0) begin
      e.rd = lr; e.data = ld; e.cyc = cyc; exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    ex_valid = 1'b0;
    ls_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    ls_valid = 0; ls_rd = 0; ls_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    #1;
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ex write on the first edge after reset release, then hold check.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("wb_reg_write", 32'(reg_write), 32'd1);
    idle();
    check("wb_reg_write_clears", 32'(reg_write), 32'd0);
    check("hold_rd", 32'(rd), 32'd5);
    check("hold_rd_data", rd_data, 32'hDEADBEEF);

    // Write to x0 is consumed but never committed.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1);
    check("x0_no_reg_write", 32'(reg_write), 32'd0);
    idle();

    // Contention: ls wins 4 cycles, ex once, ls again; then a second starvation
    // episode where ex drops valid while holding priority.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 5'd10, 32'hE000_0000 + 32'(i), 1'b1, 5'd12, 32'h1000 + 32'(i),
           (i == 4), (i != 4));
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h2222, 1'b0, 1'b1);
    step(1'b1, 5'd14, 32'h3333, 1'b1, 5'd15, 32'h4444, 1'b1, 1'b0);
    step(1'b1, 5'd16, 32'h5555, 1'b1, 5'd17, 32'h6666, 1'b0, 1'b1);
    idle();

    // Scoreboard set, busy through the commit cycle, clear, and set-wins reissue.
    rs1 = 5'd7; rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    check("busy_before_issue", 32'(rs1_busy), 32'd0);
    idle();
    check("busy_after_issue", 32'(rs1_busy), 32'd1);
    check("rs2_x0_busy", 32'(rs2_busy), 32'd0);
    step(1'b1, 5'd7, 32'hA5A5_0007, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("busy_in_commit_cycle", 32'(rs1_busy), 32'd1);
    idle();
    check("busy_cleared", 32'(rs1_busy), 32'd0);
    step(1'b1, 5'd7, 32'h0000_0707, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    idle();
    check("reissue_set_wins", 32'(rs1_busy), 32'd1);
    rs2 = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd3;
    idle();
    check("rs2_busy", 32'(rs2_busy), 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    idle();
    check("x0_never_busy", 32'(rs1_busy), 32'd0);

    // Reset between an accepted transfer and its commit.
    rs1 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    idle();
    check("busy_9", 32'(rs1_busy), 32'd1);
    ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h9999_9999;
    @(negedge clk);
    check("midflight_ex_ready", 32'(ex_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    ex_valid = 1'b0;
    check("async_rst_reg_write", 32'(reg_write), 32'd0);
    check("async_rst_rs1_busy", 32'(rs1_busy), 32'd0);
    check("async_rst_rs2_busy", 32'(rs2_busy), 32'd0);
    @(posedge clk);
    #1;
    check("rst_discard_reg_write", 32'(reg_write), 32'd0);
    check("rst_discard_rd", 32'(rd), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_reg_write", 32'(reg_write), 32'd0);
    step(1'b1, 5'd1, 32'h0101, 1'b1, 5'd2, 32'h0202, 1'b0, 1'b1);
    idle();
    idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
